issue_select_arb: RTL and testbench
===================================

Name: issue_select_arb

Overview:
- Parametrised, registered oldest-first select stage for one functional-unit class of the out-of-order issue queue.
- Each cycle, finds the oldest queue entry whose opcode matches OP and whose request is set. Uses a binary min-age reduction tree over DEPTH entries.
- Presents the winner to the functional unit through a registered valid/ready grant port.
- Adds stall hold, same-cycle masking of the entry just issued, flush, and optional wrap-around age comparison.

Parameters:
- OP, `R_TYPE, opcode value this arbiter serves.
- OPCODE_WIDTH, 7, opcode field width.
- DEPTH, 16, issue-queue entries; power of two, 2..64.
- AGE, 5, age tag width; a smaller age means an older instruction.
- AGE_WRAP, 0:
  - 0: plain unsigned compare.
  - 1: modular compare. a is older than b iff bit AGE-1 of (a-b) mod 2^AGE is 1.
- ADDR_W, $clog2(DEPTH), entry address width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- op, input, DEPTH x OPCODE_WIDTH, per-entry opcode.
- req, input, DEPTH, per-entry ready-to-issue.
- age, input, DEPTH x AGE, per-entry age tag.
- flush, input, 1, pipeline flush.
- gnt_valid, output, 1, registered grant valid.
- gnt_ready, input, 1, functional unit accepts grant.
- gnt_addr, output, ADDR_W, queue address of granted entry.
- gnt_age, output, AGE, age of granted entry.
- issue_fire, output, 1, gnt_valid & gnt_ready; tells the issue queue to deallocate gnt_addr.

Behaviour:
- Eligibility: elig[i] = req[i] & (op[i]==OP) & ~mask[i]. All DEPTH entries are eligible candidates, including the top index.
- Issued-entry mask: mask[i] = issue_fire & (gnt_addr==i). This blocks re-selecting the entry being issued, because the queue clears its req only at the same edge.
- Select tree: log2(DEPTH) levels of pairwise reduction, carrying (valid, age, addr) per node.
  - Only one child valid: that child wins.
  - Neither child valid: node invalid; its age/addr are don't-care but must be deterministic (left child).
  - Both children valid: the strictly older child wins. On equal age, the left (lower-index) child wins.
  - Result: sel_valid, sel_addr, sel_age. The tree is purely combinational within the cycle.
- Output register load condition: load = ~gnt_valid | gnt_ready.
  - On load: gnt_valid <= sel_valid; gnt_addr <= sel_addr; gnt_age <= sel_age.
  - Otherwise (stall): all gnt_* hold stable. A newer or older arriving request never replaces a stalled grant.
- Flush has priority over load: gnt_valid <= 0 at the next edge. gnt_addr/gnt_age hold.
  - issue_fire is still asserted combinationally in the flush cycle if gnt_valid & gnt_ready.
- Latency: a request visible in cycle N appears on gnt_* in cycle N+1 if the output stage is empty or draining. Sustained throughput is 1 grant/cycle with gnt_ready held high.
- Reset (rst_n low, asynchronous): gnt_valid=0, gnt_addr=0, gnt_age=0. issue_fire is therefore 0. Reset mid-stall drops the pending grant.
- No eligible entry while loading: gnt_valid goes to 0.
- Ready without valid: gnt_ready while gnt_valid=0 is legal and has no effect except allowing load.
- AGE_WRAP=1: the caller guarantees live ages span < 2^(AGE-1). Outside that span, ordering is undefined but the output must still be a valid eligible address.

Test Plan:
- Basic select, DEPTH=16, AGE_WRAP=0: entries 3,9,15 match OP with ages 7,2,5; gnt_ready=1 -> next cycle gnt_valid=1, gnt_addr=9, gnt_age=2, issue_fire=1.
- Top entry and tie:
  - Only entry 15 eligible, age 0 -> gnt_addr=15.
  - Entries 4 and 12 both age 6 -> gnt_addr=4.
  - Entry 5 with matching age but op!=OP is never granted.
- Stall hold and mask:
  - Entries 2(age 4) and 6(age 1) eligible, gnt_ready=0 for 3 cycles: gnt_addr=6 stays stable even when entry 8 (age 0) arrives.
  - Raise gnt_ready with req[6] still 1 that cycle: next grant is 8, then 2; entry 6 is never granted twice.
- Back-to-back: 4 eligible entries with ages 3,1,0,2 at addresses 0..3; gnt_ready=1 and the queue clears req on issue_fire -> grants 2,1,3,0 on four consecutive cycles, then gnt_valid=0.
- Wrap compare, AGE=5, AGE_WRAP=1: ages 30 (entry 1) and 2 (entry 7) -> gnt_addr=1. Same stimulus with AGE_WRAP=0 -> gnt_addr=7.
- Flush and reset:
  - Flush during a stalled valid grant -> gnt_valid=0 next cycle; reload occurs the following cycle.
  - rst_n pulsed low mid-cycle -> gnt_valid, gnt_addr, gnt_age read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_select_arb_if.sv
// issue_select_arb_if
//   This is the bundle between the issue queue and the oldest-first select stage of
//   one functional-unit class. It carries the per-entry candidate state and the grant port.
//   master : the issue queue / functional-unit side. It drives the candidates, flush and gnt_ready.
//   slave  : the arbiter. It drives gnt_valid, gnt_addr, gnt_age and issue_fire.
//   Signals:
//     op[DEPTH][OPCODE_WIDTH]  per-entry opcode
//     req[DEPTH]               per-entry ready-to-issue
//     age[DEPTH][AGE]          per-entry age tag (smaller = older)
//     flush                    pipeline flush
//     gnt_valid/gnt_ready      registered grant handshake
//     gnt_addr/gnt_age         granted entry address and age
//     issue_fire               gnt_valid & gnt_ready (deallocate gnt_addr)
interface issue_select_arb_if #(
  parameter int OPCODE_WIDTH = 7,
  parameter int DEPTH        = 16,
  parameter int AGE          = 5,
  parameter int ADDR_W       = $clog2(DEPTH)
);
  logic [DEPTH-1:0][OPCODE_WIDTH-1:0] op;
  logic [DEPTH-1:0]                   req;
  logic [DEPTH-1:0][AGE-1:0]          age;
  logic                               flush;
  logic                               gnt_valid;
  logic                               gnt_ready;
  logic [ADDR_W-1:0]                  gnt_addr;
  logic [AGE-1:0]                     gnt_age;
  logic                               issue_fire;

  modport master (
    output op, req, age, flush, gnt_ready,
    input  gnt_valid, gnt_addr, gnt_age, issue_fire
  );

  modport slave (
    input  op, req, age, flush, gnt_ready,
    output gnt_valid, gnt_addr, gnt_age, issue_fire
  );
endinterface

// File: rtl/issue_select_arb.sv
// issue_select_arb
//   This is the registered oldest-first select stage for one functional-unit class of
//   the out-of-order issue queue. Each cycle it finds the oldest entry that has its
//   request set and an opcode equal to OP. A binary min-age tree of
//   issue_select_node instances does the search. The winner goes into a
//   valid/ready grant register.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    issue_select_arb_if.slave (candidates in, grant port out)
//   Parameters:
//     OP            opcode served by this arbiter
//     OPCODE_WIDTH  opcode field width
//     DEPTH         issue-queue entries (power of two, 2..64)
//     AGE           age tag width; a smaller tag is older
//     AGE_WRAP      0: plain unsigned compare, 1: modular (wrap-around) compare
//     ADDR_W        entry address width
`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif

// One reduction node. The right child wins only when it is valid and the
// left child is either invalid or strictly younger. So on an age tie, or
// when both children are invalid, the left child is passed up and the
// don't-care outputs stay deterministic.
module issue_select_node #(
  parameter int AGE      = 5,
  parameter int ADDR_W   = 4,
  parameter bit AGE_WRAP = 1'b0
) (
  input  logic              l_vld_i,
  input  logic [AGE-1:0]    l_age_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic              r_vld_i,
  input  logic [AGE-1:0]    r_age_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              y_vld_o,
  output logic [AGE-1:0]    y_age_o,
  output logic [ADDR_W-1:0] y_addr_o
);
  logic [AGE-1:0] diff;
  logic           r_older;
  logic           take_r;

  // Modular compare: r is older than l iff (r - l) mod 2^AGE has its MSB set.
  assign diff    = r_age_i - l_age_i;
  assign r_older = AGE_WRAP ? diff[AGE-1] : (r_age_i < l_age_i);
  assign take_r  = r_vld_i & (~l_vld_i | r_older);

  assign y_vld_o  = l_vld_i | r_vld_i;
  assign y_age_o  = take_r ? r_age_i  : l_age_i;
  assign y_addr_o = take_r ? r_addr_i : l_addr_i;
endmodule

module issue_select_arb #(
  parameter int                    OPCODE_WIDTH = 7,
  parameter logic [OPCODE_WIDTH-1:0] OP         = `R_TYPE,
  parameter int                    DEPTH        = 16,
  parameter int                    AGE          = 5,
  parameter bit                    AGE_WRAP     = 1'b0,
  parameter int                    ADDR_W       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  issue_select_arb_if.slave    bus
);
  localparam int NODES = 2 * DEPTH;

  // Heap-ordered tree. Node k has children 2k (left, lower index) and 2k+1.
  // The leaves sit at DEPTH..2*DEPTH-1 and the root is node 1.
  logic              n_vld  [1:NODES-1];
  logic [AGE-1:0]    n_age  [1:NODES-1];
  logic [ADDR_W-1:0] n_addr [1:NODES-1];

  logic [DEPTH-1:0]  elig;
  logic              fire;
  logic              load;

  logic              gnt_valid_q, gnt_valid_d;
  logic [ADDR_W-1:0] gnt_addr_q,  gnt_addr_d;
  logic [AGE-1:0]    gnt_age_q,   gnt_age_d;

  assign fire = gnt_valid_q & bus.gnt_ready;

  // The queue clears req for the issued entry only at the issuing edge.
  // Until then, that entry is masked here so it cannot be selected a second time.
  for (genvar i = 0; i < DEPTH; i++) begin : g_leaf
    assign elig[i]            = bus.req[i] & (bus.op[i] == OP) &
                                ~(fire & (gnt_addr_q == ADDR_W'(i)));
    assign n_vld[DEPTH + i]   = elig[i];
    assign n_age[DEPTH + i]   = bus.age[i];
    assign n_addr[DEPTH + i]  = ADDR_W'(i);
  end

  for (genvar k = 1; k < DEPTH; k++) begin : g_node
    issue_select_node #(.AGE(AGE), .ADDR_W(ADDR_W), .AGE_WRAP(AGE_WRAP)) u_node (
      .l_vld_i  (n_vld[2*k]),
      .l_age_i  (n_age[2*k]),
      .l_addr_i (n_addr[2*k]),
      .r_vld_i  (n_vld[2*k+1]),
      .r_age_i  (n_age[2*k+1]),
      .r_addr_i (n_addr[2*k+1]),
      .y_vld_o  (n_vld[k]),
      .y_age_o  (n_age[k]),
      .y_addr_o (n_addr[k])
    );
  end

  // While the register is stalled it keeps its grant, so a request that arrives later
  // cannot replace a grant that the unit has not yet taken.
  assign load = ~gnt_valid_q | bus.gnt_ready;

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_addr_d  = gnt_addr_q;
    gnt_age_d   = gnt_age_q;
    if (bus.flush) begin
      gnt_valid_d = 1'b0;
    end else if (load) begin
      gnt_valid_d = n_vld[1];
      gnt_addr_d  = n_addr[1];
      gnt_age_d   = n_age[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_valid_q <= 1'b0;
      gnt_addr_q  <= '0;
      gnt_age_q   <= '0;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_addr_q  <= gnt_addr_d;
      gnt_age_q   <= gnt_age_d;
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_addr   = gnt_addr_q;
  assign bus.gnt_age    = gnt_age_q;
  assign bus.issue_fire = fire;
endmodule

// File: tb/tb_issue_select_arb.sv
// tb_issue_select_arb
//   This bench uses directed vectors with hand-computed expectations. dut_a uses a plain age compare
//   and dut_b uses the wrap-around compare. Both DUTs see the same stimulus.
`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif

module tb_issue_select_arb;
  localparam int DEPTH = 16;
  localparam int OPW   = 7;
  localparam int AGE   = 5;
  localparam int AW    = 4;
  localparam logic [OPW-1:0] OP  = `R_TYPE;
  localparam logic [OPW-1:0] OTH = 7'h13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DEPTH-1:0][OPW-1:0] op_s;
  logic [DEPTH-1:0]          req_s;
  logic [DEPTH-1:0][AGE-1:0] age_s;
  logic                      flush_s;
  logic                      rdy_s;

  int n_chk  = 0;
  int n_fail = 0;

  issue_select_arb_if #(.OPCODE_WIDTH(OPW), .DEPTH(DEPTH), .AGE(AGE)) ifa ();
  issue_select_arb_if #(.OPCODE_WIDTH(OPW), .DEPTH(DEPTH), .AGE(AGE)) ifb ();

  assign ifa.op = op_s;  assign ifa.req = req_s;  assign ifa.age = age_s;
  assign ifa.flush = flush_s;  assign ifa.gnt_ready = rdy_s;
  assign ifb.op = op_s;  assign ifb.req = req_s;  assign ifb.age = age_s;
  assign ifb.flush = flush_s;  assign ifb.gnt_ready = rdy_s;

  issue_select_arb #(.OPCODE_WIDTH(OPW), .OP(OP), .DEPTH(DEPTH), .AGE(AGE), .AGE_WRAP(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  issue_select_arb #(.OPCODE_WIDTH(OPW), .OP(OP), .DEPTH(DEPTH), .AGE(AGE), .AGE_WRAP(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    req_s = '0;
    age_s = '0;
    for (int i = 0; i < DEPTH; i++) op_s[i] = OTH;
  endtask

  task automatic set_e(input int i, input logic [AGE-1:0] a);
    op_s[i]  = OP;
    req_s[i] = 1'b1;
    age_s[i] = a;
  endtask

  // Advance one clock. This acts as the queue: an entry that issued in the cycle
  // just ended has its req dropped at that edge.
  task automatic step_q();
    logic          f;
    logic [AW-1:0] a;
    f = ifa.issue_fire;
    a = ifa.gnt_addr;
    @(posedge clk);
    #2;
    if (f) req_s[a] = 1'b0;
  endtask

  initial begin
    int exp_b2b [4] = '{2, 1, 3, 0};
    int ages_b2b[4] = '{3, 1, 0, 2};

    clear_q();
    flush_s = 1'b0;
    rdy_s   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(ifa.gnt_valid), 0);
    chk("rst_addr",  32'(ifa.gnt_addr),  0);
    chk("rst_age",   32'(ifa.gnt_age),   0);
    chk("rst_fire",  32'(ifa.issue_fire), 0);
    rst_n = 1'b1;

    // basic select; entry 5 is older but has the wrong opcode
    set_e(3, 7); set_e(9, 2); set_e(15, 5);
    req_s[5] = 1'b1; age_s[5] = 0;
    rdy_s = 1'b1;
    step_q(); #1;
    chk("basic_valid", 32'(ifa.gnt_valid), 1);
    chk("basic_addr",  32'(ifa.gnt_addr),  9);
    chk("basic_age",   32'(ifa.gnt_age),   2);
    chk("basic_fire",  32'(ifa.issue_fire), 1);
    step_q();
    chk("basic_next_addr", 32'(ifa.gnt_addr), 15);
    chk("basic_next_age",  32'(ifa.gnt_age),  5);
    clear_q();
    step_q();
    chk("basic_empty", 32'(ifa.gnt_valid), 0);

    // top entry, then masked the cycle it issues
    set_e(15, 0);
    step_q();
    chk("top_valid", 32'(ifa.gnt_valid), 1);
    chk("top_addr",  32'(ifa.gnt_addr),  15);
    step_q();
    chk("top_mask", 32'(ifa.gnt_valid), 0);

    // equal ages: lower index wins
    set_e(4, 6); set_e(12, 6);
    step_q();
    chk("tie_addr", 32'(ifa.gnt_addr), 4);
    clear_q();
    step_q();

    // stall hold, then the masked drain
    rdy_s = 1'b0;
    set_e(2, 4); set_e(6, 1);
    step_q(); #1;
    chk("stall_addr0", 32'(ifa.gnt_addr), 6);
    chk("stall_fire0", 32'(ifa.issue_fire), 0);
    set_e(8, 0);
    step_q();
    chk("stall_addr1", 32'(ifa.gnt_addr), 6);
    step_q();
    chk("stall_addr2", 32'(ifa.gnt_addr), 6);
    chk("stall_age2",  32'(ifa.gnt_age),  1);
    rdy_s = 1'b1; #1;
    chk("stall_fire", 32'(ifa.issue_fire), 1);
    step_q();
    chk("drain_addr8", 32'(ifa.gnt_addr), 8);
    step_q();
    chk("drain_addr2", 32'(ifa.gnt_addr), 2);
    step_q();
    chk("drain_empty", 32'(ifa.gnt_valid), 0);

    // back-to-back
    clear_q();
    for (int i = 0; i < 4; i++) set_e(i, AGE'(ages_b2b[i]));
    for (int i = 0; i < 4; i++) begin
      step_q();
      chk("b2b_valid", 32'(ifa.gnt_valid), 1);
      chk("b2b_addr",  32'(ifa.gnt_addr),  32'(exp_b2b[i]));
    end
    step_q();
    chk("b2b_empty", 32'(ifa.gnt_valid), 0);

    // wrap-around compare vs plain compare
    clear_q();
    set_e(1, 30); set_e(7, 2);
    step_q();
    chk("nowrap_addr", 32'(ifa.gnt_addr),  7);
    chk("wrap_valid",  32'(ifb.gnt_valid), 1);
    chk("wrap_addr",   32'(ifb.gnt_addr),  1);
    chk("wrap_age",    32'(ifb.gnt_age),   30);
    clear_q();
    step_q();

    // flush during a stalled grant
    rdy_s = 1'b0;
    set_e(5, 3);
    step_q();
    chk("fl_pre_valid", 32'(ifa.gnt_valid), 1);
    flush_s = 1'b1; #1;
    chk("fl_fire_stall", 32'(ifa.issue_fire), 0);
    step_q();
    chk("fl_valid", 32'(ifa.gnt_valid), 0);
    chk("fl_addr",  32'(ifa.gnt_addr),  5);
    flush_s = 1'b0;
    step_q();
    chk("fl_reload_valid", 32'(ifa.gnt_valid), 1);
    chk("fl_reload_addr",  32'(ifa.gnt_addr),  5);
    rdy_s = 1'b1; flush_s = 1'b1; #1;
    chk("fl_fire", 32'(ifa.issue_fire), 1);
    step_q();
    chk("fl_fire_valid", 32'(ifa.gnt_valid), 0);
    flush_s = 1'b0;
    clear_q();
    step_q();

    // asynchronous reset mid-stall
    rdy_s = 1'b0;
    set_e(10, 9);
    step_q();
    chk("prerst_addr", 32'(ifa.gnt_addr), 10);
    chk("prerst_age",  32'(ifa.gnt_age),  9);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ifa.gnt_valid), 0);
    chk("arst_addr",  32'(ifa.gnt_addr),  0);
    chk("arst_age",   32'(ifa.gnt_age),   0);
    chk("arst_fire",  32'(ifa.issue_fire), 0);
    rst_n = 1'b1;
    clear_q();
    step_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
